// File: rtl/resp_demux.sv
// Routes an in-order memory response stream to the ZERO (fetch) and ONE (data)
// requesters using a tag FIFO of request selects and a one-entry slot per port.
module resp_demux_slot #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);
    // A slot being drained this cycle can take new data in the same cycle.
    assign free = !valid || ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

module resp_demux #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_FIRE,
    input  logic                     REQ_SEL,
    output logic                     REQ_STALL,
    input  logic                     RESP_VALID,
    input  logic [DATA_W-1:0]        RESP_DATA,
    output logic                     RESP_READY,
    output logic                     ZERO_VALID,
    output logic [DATA_W-1:0]        ZERO_DATA,
    input  logic                     ZERO_READY,
    output logic                     ONE_VALID,
    output logic [DATA_W-1:0]        ONE_DATA,
    input  logic                     ONE_READY,
    output logic [$clog2(DEPTH):0]   PENDING,
    output logic                     ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]           tags;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              cnt;
    logic                       head, push, pop, empty;
    logic [1:0]                 slot_free, slot_ready, slot_load, slot_valid;
    logic [1:0][DATA_W-1:0]     slot_data;

    assign empty      = (cnt == '0);
    assign REQ_STALL  = (cnt == CW'(DEPTH));
    assign push       = REQ_FIRE && !REQ_STALL;
    assign head       = tags[rd_ptr];
    assign RESP_READY = !empty && slot_free[head];
    assign pop        = RESP_VALID && RESP_READY;
    assign PENDING    = cnt;

    assign slot_ready = {ONE_READY, ZERO_READY};

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_slot
            assign slot_load[i] = pop && (head == 1'(i));
            resp_demux_slot #(.DATA_W(DATA_W)) u_slot (
                .CLK   (CLK),
                .RST   (RST),
                .load  (slot_load[i]),
                .din   (RESP_DATA),
                .ready (slot_ready[i]),
                .valid (slot_valid[i]),
                .data  (slot_data[i]),
                .free  (slot_free[i])
            );
        end
    endgenerate

    assign ZERO_VALID = slot_valid[0];
    assign ZERO_DATA  = slot_data[0];
    assign ONE_VALID  = slot_valid[1];
    assign ONE_DATA   = slot_data[1];

    // Pop reads the registered head, so a tag pushed this cycle is never popped with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ERR    <= 1'b0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= REQ_SEL;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if ((REQ_FIRE && REQ_STALL) || (RESP_VALID && empty))
                ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_resp_demux.sv
// Directed table-driven bench for resp_demux (DATA_W=32, DEPTH=4).
module tb_resp_demux;
    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_FIRE, REQ_SEL, REQ_STALL;
    logic        RESP_VALID, RESP_READY;
    logic [31:0] RESP_DATA;
    logic        ZERO_VALID, ZERO_READY, ONE_VALID, ONE_READY;
    logic [31:0] ZERO_DATA, ONE_DATA;
    logic [2:0]  PENDING;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    resp_demux #(.DATA_W(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_FIRE(REQ_FIRE), .REQ_SEL(REQ_SEL), .REQ_STALL(REQ_STALL),
        .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_READY(RESP_READY),
        .ZERO_VALID(ZERO_VALID), .ZERO_DATA(ZERO_DATA), .ZERO_READY(ZERO_READY),
        .ONE_VALID(ONE_VALID), .ONE_DATA(ONE_DATA), .ONE_READY(ONE_READY),
        .PENDING(PENDING), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fire, sel, rv;
        logic [31:0] rd;
        logic        zrdy, ordy;
        logic        rr, stall;
        logic [2:0]  pend;
        logic        zv;
        logic [31:0] zd;
        logic        ov;
        logic [31:0] od;
        logic        err;
    } vec_t;

    function automatic vec_t mk(logic fire, logic sel, logic rv, logic [31:0] rd,
                                logic zrdy, logic ordy, logic rr, logic stall,
                                logic [2:0] pend, logic zv, logic [31:0] zd,
                                logic ov, logic [31:0] od, logic err);
        vec_t v;
        v.fire = fire; v.sel = sel; v.rv = rv; v.rd = rd; v.zrdy = zrdy; v.ordy = ordy;
        v.rr = rr; v.stall = stall; v.pend = pend; v.zv = zv; v.zd = zd;
        v.ov = ov; v.od = od; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_zero(input int idx);
        chk("rst_stall", idx, 32'(REQ_STALL), 0);
        chk("rst_rready", idx, 32'(RESP_READY), 0);
        chk("rst_zvalid", idx, 32'(ZERO_VALID), 0);
        chk("rst_zdata", idx, ZERO_DATA, 0);
        chk("rst_ovalid", idx, 32'(ONE_VALID), 0);
        chk("rst_odata", idx, ONE_DATA, 0);
        chk("rst_pending", idx, 32'(PENDING), 0);
        chk("rst_err", idx, 32'(ERR), 0);
    endtask

    // Called at posedge+1: drive, check combinational ready, clock, check registers.
    task automatic run_vec(input vec_t v, input int idx);
        REQ_FIRE = v.fire; REQ_SEL = v.sel; RESP_VALID = v.rv; RESP_DATA = v.rd;
        ZERO_READY = v.zrdy; ONE_READY = v.ordy;
        #3;
        chk("resp_ready", idx, 32'(RESP_READY), 32'(v.rr));
        @(posedge CLK); #1;
        chk("req_stall", idx, 32'(REQ_STALL), 32'(v.stall));
        chk("pending", idx, 32'(PENDING), 32'(v.pend));
        chk("zero_valid", idx, 32'(ZERO_VALID), 32'(v.zv));
        if (v.zv) chk("zero_data", idx, ZERO_DATA, v.zd);
        chk("one_valid", idx, 32'(ONE_VALID), 32'(v.ov));
        if (v.ov) chk("one_data", idx, ONE_DATA, v.od);
        chk("err", idx, 32'(ERR), 32'(v.err));
    endtask

    vec_t tbl[19];
    vec_t seq_b[4];
    vec_t seq_c[10];

    initial begin
        // Interleave 0,1,0 with both ready; then fill, overflow, HOL and refill.
        tbl[0]  = mk(1,0,0,0,      1,1, 0,0,1, 0,0,      0,0,      0);
        tbl[1]  = mk(1,1,0,0,      1,1, 1,0,2, 0,0,      0,0,      0);
        tbl[2]  = mk(1,0,0,0,      1,1, 1,0,3, 0,0,      0,0,      0);
        tbl[3]  = mk(0,0,1,'hA,    1,1, 1,0,2, 1,'hA,    0,0,      0);
        tbl[4]  = mk(0,0,1,'hB,    1,1, 1,0,1, 0,0,      1,'hB,    0);
        tbl[5]  = mk(0,0,1,'hC,    1,1, 1,0,0, 1,'hC,    0,0,      0);
        tbl[6]  = mk(0,0,0,0,      1,1, 0,0,0, 0,0,      0,0,      0);
        tbl[7]  = mk(1,0,0,0,      0,0, 0,0,1, 0,0,      0,0,      0);
        tbl[8]  = mk(1,1,0,0,      0,0, 1,0,2, 0,0,      0,0,      0);
        tbl[9]  = mk(1,0,0,0,      0,0, 1,0,3, 0,0,      0,0,      0);
        tbl[10] = mk(1,1,0,0,      0,0, 1,1,4, 0,0,      0,0,      0);
        tbl[11] = mk(1,0,0,0,      0,0, 1,1,4, 0,0,      0,0,      1);
        tbl[12] = mk(0,0,1,'h100,  0,0, 1,0,3, 1,'h100,  0,0,      1);
        tbl[13] = mk(0,0,1,'h200,  0,0, 1,0,2, 1,'h100,  1,'h200,  1);
        tbl[14] = mk(0,0,1,'h300,  0,0, 0,0,2, 1,'h100,  1,'h200,  1);
        tbl[15] = mk(0,0,1,'h300,  1,0, 1,0,1, 1,'h300,  1,'h200,  1);
        tbl[16] = mk(0,0,1,'h400,  0,0, 0,0,1, 1,'h300,  1,'h200,  1);
        tbl[17] = mk(0,0,1,'h400,  0,1, 1,0,0, 1,'h300,  1,'h400,  1);
        tbl[18] = mk(0,0,0,0,      1,1, 0,0,0, 0,0,      0,0,      1);
        // Build PENDING=3 with ZERO_VALID=1 (last step pushes and pops together).
        seq_b[0] = mk(1,0,0,0,     0,0, 0,0,1, 0,0,      0,0,      1);
        seq_b[1] = mk(1,0,0,0,     0,0, 1,0,2, 0,0,      0,0,      1);
        seq_b[2] = mk(1,1,0,0,     0,0, 1,0,3, 0,0,      0,0,      1);
        seq_b[3] = mk(1,0,1,'h77,  0,0, 1,0,3, 1,'h77,   0,0,      1);
        // After reset: normal pair, spurious response, then ONE-port HOL blocking.
        seq_c[0] = mk(1,1,0,0,     0,0, 0,0,1, 0,0,      0,0,      0);
        seq_c[1] = mk(0,0,1,'h55,  0,0, 1,0,0, 0,0,      1,'h55,   0);
        seq_c[2] = mk(0,0,1,'h66,  0,0, 0,0,0, 0,0,      1,'h55,   1);
        seq_c[3] = mk(1,1,0,0,     0,1, 0,0,1, 0,0,      0,0,      1);
        seq_c[4] = mk(1,1,0,0,     0,0, 1,0,2, 0,0,      0,0,      1);
        seq_c[5] = mk(1,0,1,'h11,  0,0, 1,0,2, 0,0,      1,'h11,   1);
        seq_c[6] = mk(0,0,1,'h22,  0,0, 0,0,2, 0,0,      1,'h11,   1);
        seq_c[7] = mk(0,0,1,'h22,  0,0, 0,0,2, 0,0,      1,'h11,   1);
        seq_c[8] = mk(0,0,1,'h22,  0,1, 1,0,1, 0,0,      1,'h22,   1);
        seq_c[9] = mk(0,0,1,'h33,  0,0, 1,0,0, 1,'h33,   1,'h22,   1);

        RST = 1'b1; REQ_FIRE = 0; REQ_SEL = 0; RESP_VALID = 0; RESP_DATA = '0;
        ZERO_READY = 0; ONE_READY = 0;
        #12;
        chk_zero(0);
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int k = 0; k < 19; k++) run_vec(tbl[k], k);
        for (int k = 0; k < 4; k++) run_vec(seq_b[k], 100 + k);

        // Asynchronous reset pulse between edges with work in flight.
        REQ_FIRE = 0; RESP_VALID = 0; ZERO_READY = 0; ONE_READY = 0;
        #1; RST = 1'b1;
        #1; chk_zero(1);
        #1; RST = 1'b0;
        @(posedge CLK); #1;
        chk_zero(2);

        for (int k = 0; k < 10; k++) run_vec(seq_c[k], 200 + k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
